program_loader: RTL

Serial program loader for the FRANK processor family. It accepts a byte stream over a valid/ready handshake, assembles bytes into instruction words (most significant byte first), and writes them to consecutive instruction-memory addresses starting at 0. The processor is held in reset until the load completes. The block sits between a byte source (UART receiver or test host) and the write/address side of the program counter plus instruction memory.

---
 rtl/program_loader_if.sv | 35 +++
 rtl/program_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// program_loader_if: bundles the byte-stream handshake, the instruction-memory
// load bus and the load status lines between the loader and its environment.
//   start            single-cycle load request
//   in_data/in_valid byte source side of the handshake
//   in_ready         loader accepts a byte this cycle
//   load_addr/_data  write address (PC load) and assembled word (memory din)
//   load_we          one-cycle memory write enable per word
//   cpu_hold         processor held in reset while high
//   busy/done        load in progress / last load completed
// master = program_loader, slave = byte source plus memory/PC side.
interface program_loader_if #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) ();
  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [addr_width-1:0] load_addr;
  logic [data_width-1:0] load_data;
  logic                  load_we;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, in_data, in_valid,
    output in_ready, load_addr, load_data, load_we, cpu_hold, busy, done
  );

  modport slave (
    output start, in_data, in_valid,
    input  in_ready, load_addr, load_data, load_we, cpu_hold, busy, done
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: receives a header byte H followed by (H+1) words of
// data_width/8 bytes each (MSB first) and writes the words to consecutive
// instruction-memory addresses starting at 0, holding the CPU in reset until
// the load completes.
//   clk  rising-edge clock
//   rst  synchronous reset, active low
//   bus  program_loader_if.master (stream in, load bus out, status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start; CPU held
// S_HDR   | accepting the header byte (word count - 1)
// S_BYTE  | accepting data bytes of the current word
// S_SETUP | address/word stable one cycle ahead of the write strobe
// S_WRITE | load_we high for one cycle; next word or finish
// S_DONE  | load complete, CPU released; start begins a reload
module program_loader #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic clk,
  input  logic rst,
  program_loader_if.master bus
);
  localparam int BPW  = data_width / 8;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BYTE,
    S_SETUP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] count_q, count_d;
  logic [data_width-1:0] data_q, data_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [addr_width-1:0] hdr_count;
  logic                  in_ready;

  // Header holds count-1. Narrow memories clip it to the last address so the
  // address counter can never wrap within a load.
  generate
    if (addr_width < 8) begin : g_clip
      localparam logic [7:0] HDR_MAX = 8'((1 << addr_width) - 1);
      assign hdr_count = (bus.in_data > HDR_MAX) ? HDR_MAX[addr_width-1:0]
                                                 : bus.in_data[addr_width-1:0];
    end else begin : g_ext
      assign hdr_count = addr_width'(bus.in_data);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    data_d   = data_q;
    idx_d    = idx_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_HDR;
      end
      S_HDR: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          count_d = hdr_count;
          addr_d  = '0;
          idx_d   = '0;
          state_d = S_BYTE;
        end
      end
      S_BYTE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          // Shift in from the LSB side so the first byte lands in the MSBs.
          data_d = (data_q << 8) | data_width'(bus.in_data);
          if (idx_q == LAST_IDX) begin
            state_d = S_SETUP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SETUP: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (addr_q == count_q) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          idx_d   = '0;
          state_d = S_BYTE;
        end
      end
      S_DONE: begin
        if (bus.start) state_d = S_HDR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.load_addr = addr_q;
  assign bus.load_data = data_q;
  assign bus.load_we   = (state_q == S_WRITE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.cpu_hold  = (state_q != S_DONE);
  assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule
